// File: rtl/bus_fifo_port_pkg.sv
// bus_fifo_port_pkg
//   Shared definitions for the memory-mapped FIFO port: register offsets,
//   STATUS/CTRL bit positions and a helper that packs the STATUS word.
//   No ports; imported by bus_fifo_port.
package bus_fifo_port_pkg;

  typedef logic [1:0] reg_off_t;

  // Register offsets within the four-word window
  localparam reg_off_t OFF_TXDATA = 2'd0;
  localparam reg_off_t OFF_RXDATA = 2'd1;
  localparam reg_off_t OFF_STATUS = 2'd2;
  localparam reg_off_t OFF_CTRL   = 2'd3;

  // STATUS bit positions
  localparam int ST_TX_FULL      = 0;
  localparam int ST_TX_EMPTY     = 1;
  localparam int ST_RX_FULL      = 2;
  localparam int ST_RX_EMPTY     = 3;
  localparam int ST_TX_OVF       = 4;
  localparam int ST_RX_UNF       = 5;
  localparam int ST_TX_COUNT_LSB = 8;
  localparam int ST_RX_COUNT_LSB = 16;

  // CTRL bit positions (write-one actions, nothing is stored)
  localparam int CTRL_TX_FLUSH   = 0;
  localparam int CTRL_RX_FLUSH   = 1;
  localparam int CTRL_CLR_TX_OVF = 2;
  localparam int CTRL_CLR_RX_UNF = 3;

  // Assemble the STATUS word; every bit not listed reads as zero.
  function automatic logic [31:0] packStatus(
    input logic       txFull,
    input logic       txEmpty,
    input logic       rxFull,
    input logic       rxEmpty,
    input logic       txOvf,
    input logic       rxUnf,
    input logic [7:0] txCount,
    input logic [7:0] rxCount
  );
    logic [31:0] s;
    s = '0;
    s[ST_TX_FULL]               = txFull;
    s[ST_TX_EMPTY]              = txEmpty;
    s[ST_RX_FULL]               = rxFull;
    s[ST_RX_EMPTY]              = rxEmpty;
    s[ST_TX_OVF]                = txOvf;
    s[ST_RX_UNF]                = rxUnf;
    s[ST_TX_COUNT_LSB +: 8]     = txCount;
    s[ST_RX_COUNT_LSB +: 8]     = rxCount;
    return s;
  endfunction

endpackage

// File: rtl/bus_fifo_port_sync_fifo.sv
// sync_fifo
//   Single-clock first-word-fall-through FIFO used for both directions of
//   bus_fifo_port. The caller only asserts push when there is room (or when a
//   pop frees a slot in the same cycle) and only asserts pop when non-empty.
//   Ports:
//     clk, rst        clock, asynchronous active-high reset
//     push, din       write din at the tail
//     pop             advance past the head
//     flush           empty the FIFO; wins over a same-cycle push/pop
//     head            word at the read pointer (valid while !empty)
//     full, empty     occupancy flags
//     count           number of stored words, 0..DEPTH
module sync_fifo #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [DATA_W-1:0]        din,
  output logic [DATA_W-1:0]        head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE   = AW'(1);
  localparam logic [AW:0]   COUNT_ONE = (AW+1)'(1);
  localparam logic [AW:0]   COUNT_MAX = (AW+1)'(DEPTH);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]     r_wrPtr;
  logic [AW-1:0]     r_rdPtr;
  logic [AW:0]       r_count;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else if (flush) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else begin
      if (push) r_wrPtr <= r_wrPtr + PTR_ONE;
      if (pop)  r_rdPtr <= r_rdPtr + PTR_ONE;
      if (push && !pop)      r_count <= r_count + COUNT_ONE;
      else if (pop && !push) r_count <= r_count - COUNT_ONE;
    end
  end

  // Storage carries no reset; a flushed word is simply never read.
  always_ff @(posedge clk) begin
    if (push && !flush) r_mem[r_wrPtr] <= din;
  end

  assign head  = r_mem[r_rdPtr];
  assign full  = (r_count == COUNT_MAX);
  assign empty = (r_count == '0);
  assign count = r_count;

endmodule

// File: rtl/bus_fifo_port.sv
// bus_fifo_port
//   Memory-mapped peripheral on the CPU external data bus. A four-word window
//   at BASE_ADDR gives access to a TX FIFO (CPU -> valid/ready consumer) and an
//   RX FIFO (valid/ready producer -> CPU), plus STATUS and CTRL registers.
//   Ports:
//     CLK, RST            clock, asynchronous active-high reset
//     ADDR                word address; [1:0] selects the register
//     Data_BUS_WRITE      CPU write data
//     CS, WR_RD           bus select, 1 = write / 0 = read
//     Data_BUS_READ       registered read data, holds between selected reads
//     tx_valid/data/ready TX stream towards the consumer
//     rx_valid/data/ready RX stream from the producer
module bus_fifo_port
  import bus_fifo_port_pkg::*;
#(
  parameter int          DATA_W    = 32,
  parameter int          DEPTH     = 8,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0E00
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [31:0]       ADDR,
  input  logic [31:0]       Data_BUS_WRITE,
  input  logic              CS,
  input  logic              WR_RD,
  output logic [31:0]       Data_BUS_READ,
  output logic              tx_valid,
  output logic [DATA_W-1:0] tx_data,
  input  logic              tx_ready,
  input  logic              rx_valid,
  input  logic [DATA_W-1:0] rx_data,
  output logic              rx_ready
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic          w_sel;
  reg_off_t      w_off;
  logic          w_rdStrobe;
  logic          w_wrStrobe;
  logic          w_ctrlWr;

  logic          w_txPushReq;
  logic          w_txPush;
  logic          w_txPop;
  logic          w_txFlush;
  logic          w_txOvfSet;
  logic          w_txFull;
  logic          w_txEmpty;
  logic [CW-1:0] w_txCount;

  logic          w_rxRead;
  logic          w_rxPush;
  logic          w_rxPop;
  logic          w_rxFlush;
  logic          w_rxUnfSet;
  logic          w_rxFull;
  logic          w_rxEmpty;
  logic [CW-1:0] w_rxCount;
  logic [DATA_W-1:0] w_rxHead;

  logic          w_clrTxOvf;
  logic          w_clrRxUnf;
  logic [31:0]   w_readNext;

  logic          r_txOvf;
  logic          r_rxUnf;
  logic [31:0]   r_readData;

  // Address decode: the low two word-address bits pick the register.
  assign w_sel      = CS && (ADDR[31:2] == BASE_ADDR[31:2]);
  assign w_off      = ADDR[1:0];
  assign w_rdStrobe = w_sel && !WR_RD;
  assign w_wrStrobe = w_sel && WR_RD;
  assign w_ctrlWr   = w_wrStrobe && (w_off == OFF_CTRL);

  assign w_txFlush  = w_ctrlWr && Data_BUS_WRITE[CTRL_TX_FLUSH];
  assign w_rxFlush  = w_ctrlWr && Data_BUS_WRITE[CTRL_RX_FLUSH];
  assign w_clrTxOvf = w_ctrlWr && Data_BUS_WRITE[CTRL_CLR_TX_OVF];
  assign w_clrRxUnf = w_ctrlWr && Data_BUS_WRITE[CTRL_CLR_RX_UNF];

  // A push into a full TX FIFO still lands if the consumer frees the head slot
  // in the same cycle; otherwise the word is lost and the overflow flag is set.
  assign w_txPushReq = w_wrStrobe && (w_off == OFF_TXDATA);
  assign w_txPop     = !w_txEmpty && tx_ready;
  assign w_txPush    = w_txPushReq && (!w_txFull || w_txPop);
  assign w_txOvfSet  = w_txPushReq && w_txFull && !w_txPop;

  // The RX side has no pop bypass: a full FIFO refuses the producer outright.
  assign w_rxRead   = w_rdStrobe && (w_off == OFF_RXDATA);
  assign w_rxPop    = w_rxRead && !w_rxEmpty;
  assign w_rxUnfSet = w_rxRead && w_rxEmpty;
  assign w_rxPush   = rx_valid && !w_rxFull;

  sync_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_txFifo (
    .clk   (CLK),
    .rst   (RST),
    .push  (w_txPush),
    .pop   (w_txPop),
    .flush (w_txFlush),
    .din   (DATA_W'(Data_BUS_WRITE)),
    .head  (tx_data),
    .full  (w_txFull),
    .empty (w_txEmpty),
    .count (w_txCount)
  );

  sync_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_rxFifo (
    .clk   (CLK),
    .rst   (RST),
    .push  (w_rxPush),
    .pop   (w_rxPop),
    .flush (w_rxFlush),
    .din   (rx_data),
    .head  (w_rxHead),
    .full  (w_rxFull),
    .empty (w_rxEmpty),
    .count (w_rxCount)
  );

  // Read mux; an empty RX read and the write-only offsets return zero.
  always_comb begin
    w_readNext = '0;
    case (w_off)
      OFF_RXDATA: if (!w_rxEmpty) w_readNext = 32'(w_rxHead);
      OFF_STATUS: w_readNext = packStatus(w_txFull, w_txEmpty, w_rxFull,
                                          w_rxEmpty, r_txOvf, r_rxUnf,
                                          8'(w_txCount), 8'(w_rxCount));
      default:    w_readNext = '0;
    endcase
  end

  // Read data only changes on a selected read, so it holds for Write Back.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST)             r_readData <= '0;
    else if (w_rdStrobe) r_readData <= w_readNext;
  end

  // Sticky error flags: a same-cycle set beats the CTRL clear.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_txOvf <= 1'b0;
      r_rxUnf <= 1'b0;
    end else begin
      if (w_txOvfSet)      r_txOvf <= 1'b1;
      else if (w_clrTxOvf) r_txOvf <= 1'b0;
      if (w_rxUnfSet)      r_rxUnf <= 1'b1;
      else if (w_clrRxUnf) r_rxUnf <= 1'b0;
    end
  end

  assign Data_BUS_READ = r_readData;
  assign tx_valid      = !w_txEmpty;
  assign rx_ready      = !w_rxFull;

endmodule

// File: tb/tb_bus_fifo_port.sv
// tb_bus_fifo_port
//   Self-checking bench for bus_fifo_port: a queue-based model of both FIFOs,
//   the flags and the read register is advanced alongside the DUT and compared
//   on every falling edge, with directed sequences and literal expectations
//   followed by randomized traffic and a mid-stream reset.
module tb_bus_fifo_port;

  localparam int          DEPTH = 8;
  localparam logic [31:0] BASE  = 32'h0000_0E00;

  logic        CLK;
  logic        RST;
  logic [31:0] ADDR;
  logic [31:0] Data_BUS_WRITE;
  logic        CS;
  logic        WR_RD;
  logic [31:0] Data_BUS_READ;
  logic        tx_valid;
  logic [31:0] tx_data;
  logic        tx_ready;
  logic        rx_valid;
  logic [31:0] rx_data;
  logic        rx_ready;

  int errors = 0;
  int checks = 0;
  bit checkEn = 0;

  // Reference model state
  logic [31:0] txQ[$];
  logic [31:0] rxQ[$];
  logic [31:0] mRead;
  bit          mTxOvf;
  bit          mRxUnf;

  bus_fifo_port #(
    .DATA_W    (32),
    .DEPTH     (DEPTH),
    .BASE_ADDR (BASE)
  ) dut (
    .CLK            (CLK),
    .RST            (RST),
    .ADDR           (ADDR),
    .Data_BUS_WRITE (Data_BUS_WRITE),
    .CS             (CS),
    .WR_RD          (WR_RD),
    .Data_BUS_READ  (Data_BUS_READ),
    .tx_valid       (tx_valid),
    .tx_data        (tx_data),
    .tx_ready       (tx_ready),
    .rx_valid       (rx_valid),
    .rx_data        (rx_data),
    .rx_ready       (rx_ready)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t",
               name, actual, expected, $time);
    end
  endtask

  function automatic logic [31:0] modelStatus();
    logic [31:0] s;
    s = '0;
    s[0] = (txQ.size() == DEPTH);
    s[1] = (txQ.size() == 0);
    s[2] = (rxQ.size() == DEPTH);
    s[3] = (rxQ.size() == 0);
    s[4] = mTxOvf;
    s[5] = mRxUnf;
    s[15:8]  = 8'(txQ.size());
    s[23:16] = 8'(rxQ.size());
    return s;
  endfunction

  task automatic modelReset();
    txQ.delete();
    rxQ.delete();
    mRead  = '0;
    mTxOvf = 0;
    mRxUnf = 0;
  endtask

  // Drive one bus cycle, advance the model across the clock edge, return
  // 2 time units after the edge.
  task automatic applyStimulus(input logic cs, input logic [31:0] addr,
                               input logic wr, input logic [31:0] wdata,
                               input logic txr, input logic rxv,
                               input logic [31:0] rxd);
    bit          sel, txPop, rxAccept, cpuPush, ctrl, ovfSet, cpuPop, unfSet;
    int unsigned off;
    logic [31:0] nextRead;
    bit          nTxOvf, nRxUnf;
    CS = cs; ADDR = addr; WR_RD = wr; Data_BUS_WRITE = wdata;
    tx_ready = txr; rx_valid = rxv; rx_data = rxd;

    sel      = cs && (addr[31:2] == BASE[31:2]);
    off      = addr[1:0];
    txPop    = (txQ.size() > 0) && txr;
    rxAccept = rxv && (rxQ.size() < DEPTH);
    cpuPush  = sel && wr && (off == 0);
    ctrl     = sel && wr && (off == 3);
    ovfSet   = cpuPush && (txQ.size() == DEPTH) && !txPop;
    cpuPop   = sel && !wr && (off == 1) && (rxQ.size() > 0);
    unfSet   = sel && !wr && (off == 1) && (rxQ.size() == 0);
    nextRead = mRead;
    if (sel && !wr) begin
      case (off)
        1:       nextRead = (rxQ.size() > 0) ? rxQ[0] : 32'h0;
        2:       nextRead = modelStatus();
        default: nextRead = 32'h0;
      endcase
    end
    nTxOvf = mTxOvf;
    nRxUnf = mRxUnf;
    if (ctrl && wdata[2]) nTxOvf = 0;
    if (ctrl && wdata[3]) nRxUnf = 0;
    if (ovfSet) nTxOvf = 1;
    if (unfSet) nRxUnf = 1;

    @(posedge CLK);
    if (txPop) void'(txQ.pop_front());
    if (cpuPush && !ovfSet) txQ.push_back(wdata);
    if (ctrl && wdata[0]) txQ.delete();
    if (cpuPop) void'(rxQ.pop_front());
    if (rxAccept) rxQ.push_back(rxd);
    if (ctrl && wdata[1]) rxQ.delete();
    mRead  = nextRead;
    mTxOvf = nTxOvf;
    mRxUnf = nRxUnf;
    #2;
  endtask

  bit dTxReady = 0;

  task automatic cpuWrite(input int off, input logic [31:0] data);
    applyStimulus(1'b1, BASE + 32'(off), 1'b1, data, dTxReady, 1'b0, 32'h0);
  endtask

  task automatic cpuRead(input int off);
    applyStimulus(1'b1, BASE + 32'(off), 1'b0, 32'h0, dTxReady, 1'b0, 32'h0);
  endtask

  task automatic idleCycle();
    applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, dTxReady, 1'b0, 32'h0);
  endtask

  task automatic expectRead(input string name, input logic [31:0] val);
    @(negedge CLK);
    checkOutput(name, Data_BUS_READ, val);
  endtask

  task automatic runRandom(input int cycles, input int txBias, input int rxBias);
    logic [31:0] addr, wdata;
    int unsigned off, pick;
    logic cs, wr, txr, rxv;
    for (int i = 0; i < cycles; i++) begin
      cs   = ($urandom_range(0, 9) != 0);
      off  = $urandom_range(0, 3);
      pick = $urandom_range(0, 15);
      if (pick == 0)      addr = BASE + 32'd4 + 32'(off);
      else if (pick == 1) addr = $urandom;
      else                addr = BASE + 32'(off);
      wr    = 1'($urandom_range(0, 1));
      wdata = $urandom;
      if (off == 3 && $urandom_range(0, 7) != 0) wdata[1:0] = 2'b00;
      txr = ($urandom_range(0, 99) < txBias);
      rxv = ($urandom_range(0, 99) < rxBias);
      applyStimulus(cs, addr, wr, wdata, txr, rxv, $urandom);
    end
  endtask

  // Continuous comparison against the model on every falling edge.
  always @(negedge CLK) begin
    if (checkEn) begin
      checkOutput("rdata", Data_BUS_READ, mRead);
      checkOutput("tx_valid", 32'(tx_valid), 32'(txQ.size() != 0));
      if (txQ.size() != 0) checkOutput("tx_data", tx_data, txQ[0]);
      checkOutput("rx_ready", 32'(rx_ready), 32'(rxQ.size() != DEPTH));
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [31:0] exp9 [8];
    CS = 0; ADDR = 0; WR_RD = 0; Data_BUS_WRITE = 0;
    tx_ready = 0; rx_valid = 0; rx_data = 0;
    RST = 1'b0;
    #1 RST = 1'b1;
    modelReset();
    #1 checkEn = 1;
    @(posedge CLK);
    #2 RST = 1'b0;

    // Reset STATUS: both FIFOs empty
    cpuRead(2);
    expectRead("status_reset", 32'h0000_000A);

    // TX round trip
    dTxReady = 0;
    cpuWrite(0, 32'h11);
    cpuWrite(0, 32'h22);
    cpuWrite(0, 32'h33);
    cpuRead(2);
    expectRead("status_tx3", 32'h0000_0308);
    dTxReady = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      checkOutput("tx_drain", tx_data, 32'h11 * 32'(i + 1));
      idleCycle();
    end
    @(negedge CLK);
    checkOutput("tx_empty_after_drain", 32'(tx_valid), 32'h0);

    // TX overflow, clear, full push with concurrent pop
    dTxReady = 0;
    for (int i = 0; i < 9; i++) cpuWrite(0, 32'h100 + 32'(i));
    cpuRead(2);
    expectRead("status_tx_ovf", 32'h0000_0819);
    cpuWrite(3, 32'h4);
    cpuRead(2);
    expectRead("status_ovf_clr", 32'h0000_0809);
    applyStimulus(1'b1, BASE, 1'b1, 32'h200, 1'b1, 1'b0, 32'h0);
    cpuRead(2);
    expectRead("status_full_pushpop", 32'h0000_0809);
    for (int i = 0; i < 7; i++) exp9[i] = 32'h101 + 32'(i);
    exp9[7] = 32'h200;
    dTxReady = 1;
    for (int i = 0; i < 8; i++) begin
      @(negedge CLK);
      checkOutput("tx_ovf_drain", tx_data, exp9[i]);
      idleCycle();
    end
    @(negedge CLK);
    checkOutput("tx_empty_after_ovf", 32'(tx_valid), 32'h0);
    dTxReady = 0;

    // RX read latency
    applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1, 32'hDEAD_BEEF);
    cpuRead(1);
    expectRead("rx_latency", 32'hDEAD_BEEF);
    cpuRead(2);
    expectRead("status_rx_drained", 32'h0000_000A);

    // RX underflow and backpressure
    cpuRead(1);
    expectRead("rx_underflow_data", 32'h0);
    cpuRead(2);
    expectRead("status_rx_unf", 32'h0000_002A);
    for (int i = 0; i < 9; i++)
      applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h300 + 32'(i));
    @(negedge CLK);
    checkOutput("rx_ready_full", 32'(rx_ready), 32'h0);
    cpuRead(2);
    expectRead("status_rx_full", 32'h0008_0026);
    for (int i = 0; i < 8; i++) begin
      cpuRead(1);
      expectRead("rx_drain", 32'h300 + 32'(i));
    end
    cpuWrite(3, 32'h8);
    cpuRead(2);
    expectRead("status_unf_clr", 32'h0000_000A);

    // Decode: unselected accesses change nothing
    cpuWrite(0, 32'hA1);
    cpuWrite(0, 32'hA2);
    applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1, 32'hB1);
    applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1, 32'hB2);
    cpuRead(2);
    expectRead("status_pre_decode", 32'h0002_0200);
    applyStimulus(1'b0, BASE,          1'b1, 32'h55, 1'b0, 1'b0, 32'h0);
    applyStimulus(1'b1, BASE + 32'd4,  1'b1, 32'h55, 1'b0, 1'b0, 32'h0);
    applyStimulus(1'b1, BASE + 32'd5,  1'b0, 32'h0,  1'b0, 1'b0, 32'h0);
    applyStimulus(1'b0, BASE + 32'd3,  1'b1, 32'hF,  1'b0, 1'b0, 32'h0);
    applyStimulus(1'b0, BASE + 32'd2,  1'b0, 32'h0,  1'b0, 1'b0, 32'h0);
    expectRead("rdata_held", 32'h0002_0200);
    cpuRead(2);
    expectRead("status_post_decode", 32'h0002_0200);

    // Flush both with a same-cycle RX push
    applyStimulus(1'b1, BASE + 32'd3, 1'b1, 32'h3, 1'b0, 1'b1, 32'h77);
    cpuRead(2);
    expectRead("status_flushed", 32'h0000_000A);

    // Randomized traffic with a mid-stream reset
    runRandom(400, 0, 90);
    runRandom(400, 90, 10);
    CS = 0; WR_RD = 0; tx_ready = 0; rx_valid = 0;
    #1 RST = 1'b1;
    modelReset();
    #1;
    checkOutput("reset_rdata", Data_BUS_READ, 32'h0);
    checkOutput("reset_tx_valid", 32'(tx_valid), 32'h0);
    checkOutput("reset_rx_ready", 32'(rx_ready), 32'h1);
    repeat (2) @(posedge CLK);
    #2 RST = 1'b0;
    cpuRead(2);
    expectRead("status_after_reset", 32'h0000_000A);
    runRandom(400, 30, 60);
    runRandom(300, 50, 50);

    @(negedge CLK);
    checkEn = 0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
